// File: rtl/sram_ctrl.sv
`default_nettype none
// sram_ctrl: single-word initiator for an asynchronous 16-bit SRAM.
// All strobes are registered from the next state, so they are glitch-free.
module sram_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  input  logic [1:0]        be,
  output logic              ready,
  output logic              ack,
  output logic [15:0]       rdata,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic [15:0]       Data_to_SRAM,
  input  logic [15:0]       Data_from_SRAM,
  output logic              Drive_en
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         be_q, be_d;
  logic               ready_q, ack_q;
  logic               ce_n_q, ub_n_q, lb_n_q, oe_n_q, we_n_q, drive_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [15:0]        dout_q, rdata_q;
  logic               accept;
  logic               access_d;
  logic               write_d;
  logic               rd_last;

  // ready_q gates acceptance so a request is never taken in the first cycle after reset
  assign accept   = (state_q == S_IDLE) && ready_q && req;
  assign rd_last  = (state_q == S_READ) && (cnt_q == '0);
  assign write_d  = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
                    (state_d == S_WR_HOLD);
  assign access_d = write_d || (state_d == S_READ);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    be_d    = be_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          be_d = be;
          if (be == 2'b00) begin
            state_d = S_DONE;
          end else if (we) begin
            state_d = S_WR_SETUP;
          end else begin
            state_d = S_READ;
            cnt_d   = RD_LOAD;
          end
        end
      end
      S_READ: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = WR_LOAD;
      end
      S_WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_HOLD: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      be_q    <= 2'b00;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drive_q <= 1'b0;
      addr_q  <= '0;
      dout_q  <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      be_q    <= be_d;
      ready_q <= (state_d == S_IDLE);
      ack_q   <= (state_d == S_DONE);
      ce_n_q  <= !access_d;
      ub_n_q  <= !(access_d && be_d[1]);
      lb_n_q  <= !(access_d && be_d[0]);
      oe_n_q  <= (state_d != S_READ);
      we_n_q  <= (state_d != S_WR_PULSE);
      drive_q <= write_d;
      if (accept) begin
        addr_q <= addr;
        dout_q <= wdata;
      end
      if (rd_last) begin
        rdata_q <= {be_q[1] ? Data_from_SRAM[15:8] : 8'h00,
                    be_q[0] ? Data_from_SRAM[7:0]  : 8'h00};
      end
    end
  end

  assign ready        = ready_q;
  assign ack          = ack_q;
  assign rdata        = rdata_q;
  assign SRAM_ADDR    = addr_q;
  assign SRAM_CE_N    = ce_n_q;
  assign SRAM_UB_N    = ub_n_q;
  assign SRAM_LB_N    = lb_n_q;
  assign SRAM_OE_N    = oe_n_q;
  assign SRAM_WE_N    = we_n_q;
  assign Data_to_SRAM = dout_q;
  assign Drive_en     = drive_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// tb_sram_ctrl: two controller instances (default waits and RD_WAIT=1/WR_WAIT=4)
// driven by random transactions against a word-level reference memory.
module tb_sram_ctrl;
  localparam int AW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req, we;
  logic [AW-1:0] addr;
  logic [15:0]   wdata;
  logic [1:0]    be;
  logic [15:0]   pad_rd;
  int            sel;

  logic [1:0]    reqv, rdy, ackv, ce, ub, lb, oe, wen, drv;
  logic [15:0]   rd [2];
  logic [15:0]   dout [2];
  logic [AW-1:0] sa [2];

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] sram [logic [AW-1:0]];
  logic [15:0] ref_mem [logic [AW-1:0]];
  logic [15:0] exp_rdata [2];

  assign reqv = {req & (sel == 1), req & (sel == 0)};

  sram_ctrl #(.ADDR_W(AW), .RD_WAIT(2), .WR_WAIT(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(reqv[0]), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ready(rdy[0]), .ack(ackv[0]), .rdata(rd[0]), .SRAM_ADDR(sa[0]),
    .SRAM_CE_N(ce[0]), .SRAM_UB_N(ub[0]), .SRAM_LB_N(lb[0]), .SRAM_OE_N(oe[0]),
    .SRAM_WE_N(wen[0]), .Data_to_SRAM(dout[0]), .Data_from_SRAM(pad_rd),
    .Drive_en(drv[0]));

  sram_ctrl #(.ADDR_W(AW), .RD_WAIT(1), .WR_WAIT(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(reqv[1]), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ready(rdy[1]), .ack(ackv[1]), .rdata(rd[1]), .SRAM_ADDR(sa[1]),
    .SRAM_CE_N(ce[1]), .SRAM_UB_N(ub[1]), .SRAM_LB_N(lb[1]), .SRAM_OE_N(oe[1]),
    .SRAM_WE_N(wen[1]), .Data_to_SRAM(dout[1]), .Data_from_SRAM(pad_rd),
    .Drive_en(drv[1]));

  function automatic logic [15:0] init_word(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Pad-level SRAM: stores enabled bytes while CE_N and WE_N are low
  always @(posedge clk) begin : p_sram_wr
    logic [15:0] w;
    if (!ce[sel] && !wen[sel]) begin
      w = sram.exists(sa[sel]) ? sram[sa[sel]] : init_word(sa[sel]);
      if (!ub[sel]) w[15:8] = dout[sel][15:8];
      if (!lb[sel]) w[7:0]  = dout[sel][7:0];
      sram[sa[sel]] = w;
    end
  end

  always @(negedge clk) begin
    if (!ce[sel] && !oe[sel])
      pad_rd = sram.exists(sa[sel]) ? sram[sa[sel]] : init_word(sa[sel]);
    else
      pad_rd = 16'h5A5A;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ((!oe[i] && !wen[i]) || (drv[i] && !oe[i]) || (ce[i] && (!ub[i] || !lb[i]))) begin
        miscompares++;
        $display("FAIL invariant dut%0d oe_n=%b we_n=%b drive=%b ce_n=%b ub_n=%b lb_n=%b required no overlap",
                 i, oe[i], wen[i], drv[i], ce[i], ub[i], lb[i]);
      end
    end
  end

  task automatic run_txn(input logic t_we, input logic [AW-1:0] t_addr,
                         input logic [15:0] t_wdata, input logic [1:0] t_be,
                         input bit hold, input logic [AW-1:0] n_addr, input string tag);
    int s, rw, ww, len;
    bit ok, acc;
    logic [7:0] g_vec, e_vec;
    logic [15:0] d;
    logic e_ce, e_ub, e_lb, e_oe, e_we, e_drv, e_rdy, e_ack;
    s  = sel;
    rw = (s == 1) ? 1 : 2;
    ww = (s == 1) ? 4 : 2;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rdy[s]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s ready_timeout ready=%b required=1", tag, rdy[s]);
      return;
    end
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; be = t_be;
    @(posedge clk); #1;
    if (hold) begin
      we = 1'b0; addr = n_addr; be = 2'b11; wdata = 16'($urandom);
    end else begin
      req = 1'b0; we = 1'($urandom); addr = AW'($urandom);
      wdata = 16'($urandom); be = 2'($urandom);
    end
    acc = (t_be != 2'b00);
    len = !acc ? 1 : (t_we ? ww + 3 : rw + 1);
    for (int k = 1; k <= len + 1; k++) begin
      e_ce = 1'b1; e_ub = 1'b1; e_lb = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_drv = 1'b0;
      e_ack = (k == len);
      e_rdy = (k == len + 1);
      if (acc && !t_we && k <= rw) begin
        e_ce = 1'b0; e_oe = 1'b0; e_ub = ~t_be[1]; e_lb = ~t_be[0];
      end
      if (acc && t_we && k <= ww + 2) begin
        e_ce = 1'b0; e_ub = ~t_be[1]; e_lb = ~t_be[0]; e_drv = 1'b1;
        e_we = !(k >= 2 && k <= ww + 1);
      end
      e_vec = {e_ce, e_ub, e_lb, e_oe, e_we, e_drv, e_rdy, e_ack};
      g_vec = {ce[s], ub[s], lb[s], oe[s], wen[s], drv[s], rdy[s], ackv[s]};
      vectors++;
      if (g_vec !== e_vec) begin
        miscompares++;
        $display("FAIL %s strobes k=%0d {ce,ub,lb,oe,we,drv,rdy,ack} got=%b required=%b",
                 tag, k, g_vec, e_vec);
      end
      vectors++;
      if (sa[s] !== t_addr) begin
        miscompares++;
        $display("FAIL %s sram_addr k=%0d got=%h required=%h", tag, k, sa[s], t_addr);
      end
      if (e_drv) begin
        vectors++;
        if (dout[s] !== t_wdata) begin
          miscompares++;
          $display("FAIL %s wdata k=%0d got=%h required=%h", tag, k, dout[s], t_wdata);
        end
      end
      if (k == len && acc && !t_we) begin
        d = ref_rd(t_addr);
        exp_rdata[s] = {t_be[1] ? d[15:8] : 8'h00, t_be[0] ? d[7:0] : 8'h00};
      end
      if (k >= len) begin
        vectors++;
        if (rd[s] !== exp_rdata[s]) begin
          miscompares++;
          $display("FAIL %s rdata k=%0d got=%h required=%h", tag, k, rd[s], exp_rdata[s]);
        end
      end
      if (k <= len) begin
        @(posedge clk); #1;
      end
    end
    if (acc && t_we) begin
      d = ref_rd(t_addr);
      if (t_be[1]) d[15:8] = t_wdata[15:8];
      if (t_be[0]) d[7:0]  = t_wdata[7:0];
      ref_mem[t_addr] = d;
    end
  endtask

  task automatic test_reset();
    logic [7:0] g_vec;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      g_vec = {ce[i], ub[i], lb[i], oe[i], wen[i], drv[i], rdy[i], ackv[i]};
      vectors++;
      if (g_vec !== 8'b11111000 || sa[i] !== '0 || dout[i] !== 16'h0 || rd[i] !== 16'h0) begin
        miscompares++;
        $display("FAIL reset_hold dut%0d ctl=%b addr=%h dout=%h rdata=%h required ctl=11111000 zeros",
                 i, g_vec, sa[i], dout[i], rd[i]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      g_vec = {ce[i], ub[i], lb[i], oe[i], wen[i], drv[i], rdy[i], ackv[i]};
      vectors++;
      if (g_vec !== 8'b11111010 || sa[i] !== '0 || rd[i] !== 16'h0) begin
        miscompares++;
        $display("FAIL reset_idle dut%0d ctl=%b addr=%h rdata=%h required ctl=11111010 zeros",
                 i, g_vec, sa[i], rd[i]);
      end
      exp_rdata[i] = 16'h0;
    end
  endtask

  task automatic test_directed();
    run_txn(1'b1, 20'h00ABC, 16'hBEEF, 2'b11, 1'b0, '0, "wr_abc");
    run_txn(1'b0, 20'h00ABC, 16'h0000, 2'b01, 1'b0, '0, "rd_abc_lb");
    vectors++;
    if (rd[sel] !== 16'h00EF) begin
      miscompares++;
      $display("FAIL rd_abc_const got=%h required=00ef", rd[sel]);
    end
    run_txn(1'b0, 20'h00ABC, 16'h0000, 2'b10, 1'b0, '0, "rd_abc_ub");
    vectors++;
    if (rd[sel] !== 16'hBE00) begin
      miscompares++;
      $display("FAIL rd_abc_ub_const got=%h required=be00", rd[sel]);
    end
  endtask

  task automatic test_req_hold();
    logic [AW-1:0] a;
    a = 20'h12345;
    run_txn(1'b1, a, 16'hC0DE, 2'b11, 1'b1, a, "hold_wr");
    run_txn(1'b0, a, 16'h0000, 2'b11, 1'b0, '0, "hold_rd");
  endtask

  task automatic test_back_to_back();
    logic [15:0] w1, first;
    w1 = 16'($urandom);
    run_txn(1'b1, 20'h22220, w1,  2'b11, 1'b0, '0, "b2b_wr1");
    run_txn(1'b1, 20'h22221, ~w1, 2'b11, 1'b0, '0, "b2b_wr2");
    run_txn(1'b0, 20'h22220, 16'h0, 2'b11, 1'b1, 20'h22221, "b2b_rd1");
    first = exp_rdata[sel];
    run_txn(1'b0, 20'h22221, 16'h0, 2'b11, 1'b0, '0, "b2b_rd2");
    vectors++;
    if (rd[sel] === first) begin
      miscompares++;
      $display("FAIL b2b_distinct got=%h required!=%h", rd[sel], first);
    end
  endtask

  task automatic test_be_zero();
    run_txn(1'b0, 20'h33333, 16'h0, 2'b00, 1'b0, '0, "be0_rd");
    run_txn(1'b1, 20'h33334, 16'hFFFF, 2'b00, 1'b0, '0, "be0_wr");
    run_txn(1'b0, 20'h33334, 16'h0, 2'b11, 1'b0, '0, "be0_check");
  endtask

  task automatic test_reset_mid_write();
    int s;
    bit ok;
    s  = sel;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rdy[s]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    req = 1'b1; we = 1'b1; addr = 20'hF0F0F; wdata = 16'h7777; be = 2'b11;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (!ok || wen[s] !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_pulse ready_seen=%0d we_n=%b required we_n=0", ok, wen[s]);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({ce[s], wen[s], drv[s]} !== 3'b110) begin
      miscompares++;
      $display("FAIL rst_mid_async {ce_n,we_n,drive}=%b required=110", {ce[s], wen[s], drv[s]});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_rdata[0] = 16'h0;
    exp_rdata[1] = 16'h0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (ackv[s] !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_mid_no_ack cycle=%0d ack=%b required=0", i, ackv[s]);
      end
    end
    run_txn(1'b1, 20'h44440, 16'h9A9A, 2'b11, 1'b0, '0, "rst_after_wr");
    run_txn(1'b0, 20'h44440, 16'h0,    2'b11, 1'b0, '0, "rst_after_rd");
  endtask

  task automatic test_random(input int n, input string tag);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = 20'h12340 + AW'($urandom_range(0, 5));
      run_txn(1'($urandom), a, 16'($urandom), 2'($urandom), 1'b0, '0, tag);
    end
  endtask

  initial begin
    sel = 0;
    test_reset();
    test_directed();
    test_req_hold();
    test_back_to_back();
    test_be_zero();
    test_reset_mid_write();
    test_random(20, "rand_a");
    sel = 1;
    test_directed();
    test_req_hold();
    test_back_to_back();
    test_be_zero();
    test_random(20, "rand_b");
    sel = 0;
    test_random(5, "rand_a2");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
